// File: rtl/sum_acc_pkg.sv
// Shared types and default widths for the windowed sum accumulator.
package sum_acc_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ACC_WIDTH  = 16;
    localparam int DEF_CNT_WIDTH  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/sum_accumulator_if.sv
// Sample-in / result-out handshake bundle for sum_accumulator.
interface sum_accumulator_if
    import sum_acc_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
);

    logic                  in_valid;
    logic [DATA_WIDTH:0]   in_sum;
    logic                  in_ready;
    logic [CNT_WIDTH-1:0]  win_len;
    logic                  out_valid;
    logic                  out_ready;
    logic [ACC_WIDTH-1:0]  out_acc;
    logic                  out_ovf;

    // The master feeds samples and consumes results; the slave is the accumulator.
    modport master (
        output in_valid, in_sum, win_len, out_ready,
        input  in_ready, out_valid, out_acc, out_ovf
    );

    modport slave (
        input  in_valid, in_sum, win_len, out_ready,
        output in_ready, out_valid, out_acc, out_ovf
    );

endinterface

// File: rtl/sum_acc_add.sv
// Combinational accumulator adder with carry-out.
// Define SUM_ACC_SAT_EN to clamp an overflowing result to all-ones instead of wrapping.
module sum_acc_add
    import sum_acc_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic [ACC_WIDTH-1:0] acc,
    input  logic [DATA_WIDTH:0]  operand,
    output logic [ACC_WIDTH-1:0] sum,
    output logic                 carry
);

    localparam int FULL_WIDTH = ACC_WIDTH + 1;

    logic [ACC_WIDTH:0] full;

    // Once clamped, any further non-zero add carries again, so the value stays pinned.
    always_comb begin
        full  = {1'b0, acc} + FULL_WIDTH'(operand);
        carry = full[ACC_WIDTH];
`ifdef SUM_ACC_SAT_EN
        sum   = carry ? '1 : full[ACC_WIDTH-1:0];
`else
        sum   = full[ACC_WIDTH-1:0];
`endif
    end

endmodule

// File: rtl/sum_accumulator.sv
// Sums windows of win_len+1 samples and presents each total with a sticky overflow flag.
// Saturating accumulation is selected by the SUM_ACC_SAT_EN macro (see sum_acc_add).
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    sum_accumulator_if.slave bus
);

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   len_q, len_d;
    logic                   ovf_q, ovf_d;
    logic [CNT_WIDTH-1:0]   cnt_inc;
    logic [ACC_WIDTH-1:0]   add_sum;
    logic                   add_carry;
    logic                   accept;
    logic                   start_win;

    sum_acc_add #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_add (
        .acc     (acc_q),
        .operand (bus.in_sum),
        .sum     (add_sum),
        .carry   (add_carry)
    );

    assign bus.in_ready  = (state_q != HOLD) || bus.out_ready;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_acc   = acc_q;
    assign bus.out_ovf   = ovf_q;

    assign accept    = bus.in_valid && bus.in_ready;
    // A HOLD accept implies out_ready, so the result drains and the next window starts bubble-free.
    assign start_win = accept && (state_q != ACCUM);
    assign cnt_inc   = cnt_q + CNT_WIDTH'(1);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ovf_d   = ovf_q;

        case (state_q)
            ACCUM: begin
                if (accept) begin
                    acc_d = add_sum;
                    ovf_d = ovf_q | add_carry;
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (start_win) begin
            acc_d   = ACC_WIDTH'(bus.in_sum);
            cnt_d   = '0;
            len_d   = bus.win_len;
            ovf_d   = 1'b0;
            state_d = (bus.win_len == '0) ? HOLD : ACCUM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: a 12-bit-accumulator instance for the vector table
// and sequences, plus a 10-bit instance for the overflow window.
module tb_sum_accumulator;

    logic clk;
    logic rst;

    sum_accumulator_if #(.DATA_WIDTH(8), .ACC_WIDTH(12), .CNT_WIDTH(4)) bus ();
    sum_accumulator_if #(.DATA_WIDTH(8), .ACC_WIDTH(10), .CNT_WIDTH(4)) bus2 ();

    sum_accumulator #(.DATA_WIDTH(8), .ACC_WIDTH(12), .CNT_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    sum_accumulator #(.DATA_WIDTH(8), .ACC_WIDTH(10), .CNT_WIDTH(4)) dut_ovf (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    typedef struct {
        logic        in_valid;
        logic [8:0]  in_sum;
        logic [3:0]  win_len;
        logic        out_ready;
        logic        exp_in_ready;
        logic        exp_out_valid;
        logic        chk_acc;
        logic [11:0] exp_acc;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        bus.in_valid  = v.in_valid;
        bus.in_sum    = v.in_sum;
        bus.win_len   = v.win_len;
        bus.out_ready = v.out_ready;
    endtask

    task automatic add_vec(input logic v, input int s, input int wl, input logic ordy,
                           input logic rdy, input logic ov, input logic chk, input int acc,
                           input logic ovf);
        vec_t r;
        r.in_valid      = v;
        r.in_sum        = 9'(s);
        r.win_len       = 4'(wl);
        r.out_ready     = ordy;
        r.exp_in_ready  = rdy;
        r.exp_out_valid = ov;
        r.chk_acc       = chk;
        r.exp_acc       = 12'(acc);
        r.exp_ovf       = ovf;
        vecs.push_back(r);
    endtask

    initial begin
        int          n_results;
        logic [11:0] res_acc;
        logic        found;
        logic [9:0]  ovf_acc;
        logic        ovf_flag;
        logic [9:0]  exp_ovf_acc;

        // Each row: inputs for one cycle, and the outputs expected during that cycle.
        // Basic window: 10+20+30+40.
        add_vec(1, 10, 3, 1, 1, 0, 1, 0,   0);
        add_vec(1, 20, 3, 1, 1, 0, 1, 10,  0);
        add_vec(1, 30, 3, 1, 1, 0, 1, 30,  0);
        add_vec(1, 40, 3, 1, 1, 0, 1, 60,  0);
        add_vec(0, 0,  3, 1, 1, 1, 1, 100, 0);
        add_vec(0, 0,  3, 1, 1, 0, 0, 0,   0);
        // Backpressure: result held for five cycles while in_sum changes.
        add_vec(1, 10,  3, 0, 1, 0, 0, 0,   0);
        add_vec(1, 20,  3, 0, 1, 0, 1, 10,  0);
        add_vec(1, 30,  3, 0, 1, 0, 1, 30,  0);
        add_vec(1, 40,  3, 0, 1, 0, 1, 60,  0);
        add_vec(1, 99,  3, 0, 0, 1, 1, 100, 0);
        add_vec(1, 77,  0, 0, 0, 1, 1, 100, 0);
        add_vec(1, 255, 0, 0, 0, 1, 1, 100, 0);
        add_vec(0, 13,  0, 0, 0, 1, 1, 100, 0);
        add_vec(1, 1,   0, 0, 0, 1, 1, 100, 0);
        add_vec(0, 0,   3, 1, 1, 1, 1, 100, 0);
        add_vec(0, 0,   3, 1, 1, 0, 0, 0,   0);
        // Single-sample windows back to back.
        add_vec(1, 5, 0, 1, 1, 0, 0, 0, 0);
        add_vec(1, 6, 0, 1, 1, 1, 1, 5, 0);
        add_vec(1, 7, 0, 1, 1, 1, 1, 6, 0);
        add_vec(0, 0, 0, 1, 1, 1, 1, 7, 0);
        add_vec(0, 0, 0, 1, 1, 0, 0, 0, 0);
        // win_len drops to 1 mid-window: 4 samples now, 2 in the next window.
        add_vec(1, 1, 3, 1, 1, 0, 0, 0,  0);
        add_vec(1, 2, 1, 1, 1, 0, 1, 1,  0);
        add_vec(1, 3, 1, 1, 1, 0, 1, 3,  0);
        add_vec(1, 4, 1, 1, 1, 0, 1, 6,  0);
        add_vec(1, 5, 1, 1, 1, 1, 1, 10, 0);
        add_vec(1, 6, 1, 1, 1, 0, 1, 5,  0);
        add_vec(0, 0, 1, 1, 1, 1, 1, 11, 0);
        add_vec(0, 0, 1, 1, 1, 0, 0, 0,  0);

        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_sum     = '0;
        bus.win_len    = '0;
        bus.out_ready  = 1'b0;
        bus2.in_valid  = 1'b0;
        bus2.in_sum    = '0;
        bus2.win_len   = '0;
        bus2.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check_output("reset_out_valid", 32'(bus.out_valid), 0);
        check_output("reset_acc", 32'(bus.out_acc), 0);
        check_output("reset_ovf", 32'(bus.out_ovf), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check_output("post_reset_in_ready", 32'(bus.in_ready), 1);
        @(negedge clk);

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i]);
            #1;
            check_output($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'(vecs[i].exp_in_ready));
            check_output($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_out_valid));
            if (vecs[i].chk_acc) begin
                check_output($sformatf("vec%0d_out_acc", i), 32'(bus.out_acc), 32'(vecs[i].exp_acc));
                check_output($sformatf("vec%0d_out_ovf", i), 32'(bus.out_ovf), 32'(vecs[i].exp_ovf));
            end
            @(negedge clk);
        end

        // Reset in the middle of a window discards the partial sum.
        bus.in_valid  = 1'b1;
        bus.in_sum    = 9'd100;
        bus.win_len   = 4'd3;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_output("midwin_reset_acc", 32'(bus.out_acc), 0);
        check_output("midwin_reset_out_valid", 32'(bus.out_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1'b1;
            bus.in_sum   = 9'd1;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        n_results = 0;
        res_acc   = '0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (bus.out_valid) begin
                n_results++;
                res_acc = bus.out_acc;
            end
            @(negedge clk);
        end
        check_output("midwin_result_count", 32'(n_results), 1);
        check_output("midwin_result_acc", 32'(res_acc), 4);

        // Overflow on the 10-bit instance: eight samples of 510.
`ifdef SUM_ACC_SAT_EN
        exp_ovf_acc = 10'd1023;
`else
        exp_ovf_acc = 10'd1008;
`endif
        bus2.out_ready = 1'b1;
        bus2.win_len   = 4'd7;
        for (int k = 0; k < 8; k++) begin
            bus2.in_valid = 1'b1;
            bus2.in_sum   = 9'd510;
            @(negedge clk);
        end
        bus2.in_valid = 1'b0;
        found    = 1'b0;
        ovf_acc  = '0;
        ovf_flag = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (bus2.out_valid) begin
                found    = 1'b1;
                ovf_acc  = bus2.out_acc;
                ovf_flag = bus2.out_ovf;
                break;
            end
            @(negedge clk);
        end
        check_output("ovf_result_seen", 32'(found), 1);
        check_output("ovf_acc", 32'(ovf_acc), 32'(exp_ovf_acc));
        check_output("ovf_flag", 32'(ovf_flag), 1);

        // A new window started during the handshake clears the overflow flag.
        bus2.in_valid = 1'b1;
        bus2.in_sum   = 9'd3;
        bus2.win_len  = 4'd0;
        @(negedge clk);
        bus2.in_valid = 1'b0;
        #1;
        check_output("ovf_next_valid", 32'(bus2.out_valid), 1);
        check_output("ovf_next_acc", 32'(bus2.out_acc), 3);
        check_output("ovf_next_flag", 32'(bus2.out_ovf), 0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: adder operand width; the input sum is DATA_WIDTH+1 bits.
REQ-002 SHALL have parameter ACC_WIDTH, default 16: accumulator and result width; must be at least DATA_WIDTH+1.
REQ-003 SHALL have parameter CNT_WIDTH, default 4: window-length field width.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: in_sum is valid.
REQ-007 SHALL have port in_sum, input, DATA_WIDTH+1 bits: registered sum from the upstream adder stage.
REQ-008 SHALL have port in_ready, output, 1 bit: sample is accepted when in_valid and in_ready are both high.
REQ-009 SHALL have port win_len, input, CNT_WIDTH bits: window holds win_len+1 samples.
REQ-010 SHALL have port out_valid, output, 1 bit: result is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: result is consumed when out_valid and out_ready are both high.
REQ-012 SHALL have port out_acc, output, ACC_WIDTH bits: window total.
REQ-013 SHALL have port out_ovf, output, 1 bit: sticky overflow flag for the current window.

Function
REQ-014 SHALL implement the FSM states IDLE, ACCUM and HOLD.
REQ-015 In IDLE, an accepted sample SHALL load acc=in_sum, set cnt=0, latch win_len into len_q, and go to ACCUM; if win_len=0 it SHALL go directly to HOLD.
REQ-016 In ACCUM, each accepted sample SHALL add in_sum (zero-extended) to acc and increment cnt; when the accepted sample makes cnt equal len_q, the FSM SHALL go to HOLD.
REQ-017 Latency: out_valid SHALL rise in the cycle after the last sample of a window is accepted.
REQ-018 In HOLD, out_valid=1 and out_acc and out_ovf SHALL be stable until the handshake completes.
REQ-019 in_ready SHALL be 1 in IDLE and ACCUM; in HOLD, in_ready SHALL equal out_ready.
REQ-020 On a HOLD handshake with no sample accepted, the FSM SHALL go to IDLE.
REQ-021 On a HOLD handshake with a sample accepted in the same cycle, that sample SHALL start a new window exactly as in REQ-015, with no bubble.
REQ-022 Changes to win_len after the first sample of a window SHALL be ignored until the next window starts.
REQ-023 out_ovf SHALL set on any carry out of ACC_WIDTH within the window and clear when a new window starts.
REQ-024 out_acc SHALL be acc, registered; the block SHALL contain no combinational path from in_sum to out_acc.

Reset
REQ-025 Asserting rst at any time SHALL force the FSM to IDLE and set acc=0, cnt=0, len_q=0, out_valid=0, out_ovf=0.
REQ-026 A partial window in progress when rst asserts SHALL be discarded.
REQ-027 in_ready SHALL be 1 one cycle after rst deasserts.

Configuration
REQ-028 With macro SUM_ACC_SAT_EN defined, an overflowing add SHALL clamp acc to all-ones and hold it there for the rest of the window.
REQ-029 Without SUM_ACC_SAT_EN, acc SHALL wrap modulo 2^ACC_WIDTH.
REQ-030 out_ovf SHALL behave identically whether or not SUM_ACC_SAT_EN is defined.

Structure
REQ-031 Package sum_acc_pkg SHALL hold the state enum typedef (IDLE, ACCUM, HOLD) and the default width constants.
REQ-032 One sub-module, sum_acc_add, SHALL implement the combinational add with carry-out and the SUM_ACC_SAT_EN saturation logic; the FSM and registers SHALL stay in sum_accumulator.

Verification (DATA_WIDTH=8, ACC_WIDTH=12 unless stated)
REQ-033 Directed test, basic window: win_len=3, samples 10, 20, 30, 40 back-to-back, out_ready=1 -> out_valid for 1 cycle, out_acc=100, out_ovf=0.
REQ-034 Directed test, backpressure: same stream with out_ready=0 for 5 cycles -> out_acc holds 100, in_ready=0, and in_sum changes are ignored throughout.
REQ-035 Directed test, overflow with ACC_WIDTH=10: win_len=7, eight samples of 510 -> out_ovf=1; out_acc=1008 without the macro, 1023 with SUM_ACC_SAT_EN.
REQ-036 Directed test, back-to-back windows: win_len=0, in_valid=1 continuously with samples 5, 6, 7, out_ready=1 -> outputs 5, 6, 7 on consecutive cycles, each one cycle after its sample.
REQ-037 Directed test, reset mid-window: win_len=3, two samples, then rst pulse, then four samples of 1 -> the single result is out_acc=4.
REQ-038 Directed test, win_len change: win_len changes from 3 to 1 after the first sample -> the current window still takes 4 samples and the next window takes 2.
